// File: rtl/fpnew_pkg.sv
// Shared FPU types used by the result FIFO.
// status_t carries the five IEEE 754 exception flags.
package fpnew_pkg;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

endpackage

// File: rtl/fpnew_result_fifo.sv
// Result FIFO between an FPU pipeline and its consumer.
// Ports: clk_i/rst_ni, push side (result/status/ext/tag,
// in_valid_i/in_ready_o), pop side (head entry, out_valid_o/
// out_ready_i), flush_i, sticky fflags_o with clear_flags_i,
// usage_o and busy_o.
module fpnew_result_fifo
  import fpnew_pkg::*;
#(
  parameter int unsigned Width   = 32,
  parameter int unsigned Depth   = 4,
  parameter type         TagType = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [Width-1:0]           result_i,
  input  status_t                    status_i,
  input  logic                       extension_bit_i,
  input  TagType                     tag_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       flush_i,
  output logic [Width-1:0]           result_o,
  output status_t                    status_o,
  output logic                       extension_bit_o,
  output TagType                     tag_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  input  logic                       clear_flags_i,
  output status_t                    fflags_o,
  output logic [$clog2(Depth+1)-1:0] usage_o,
  output logic                       busy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  typedef struct packed {
    logic [Width-1:0] result;
    status_t          status;
    logic             ext;
    TagType           tag;
  } entry_t;

  entry_t  mem_q  [Depth];
  entry_t  mem_d  [Depth];
  ptr_t    rptr_q, rptr_d;
  ptr_t    wptr_q, wptr_d;
  cnt_t    count_q, count_d;
  status_t fflags_q, fflags_d;

  logic   push, pop;
  entry_t head;

  function automatic ptr_t incr(ptr_t p);
    return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign head        = mem_q[rptr_q];
  assign in_ready_o  = (count_q != cnt_t'(Depth));
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;

  always_comb begin
    mem_d    = mem_q;
    rptr_d   = rptr_q;
    wptr_d   = wptr_q;
    count_d  = count_q;
    fflags_d = clear_flags_i ? '0 : fflags_q;
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = '{
          result: result_i,
          status: status_i,
          ext:    extension_bit_i,
          tag:    tag_i
        };
        wptr_d = incr(wptr_q);
      end
      if (pop) begin
        rptr_d   = incr(rptr_q);
        fflags_d = fflags_d | head.status;
      end
      // push and pop together leave the count alone
      unique case (1'b1)
        push && !pop: count_d = count_q + cnt_t'(1);
        pop && !push: count_d = count_q - cnt_t'(1);
        default:      count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      count_q  <= '0;
      fflags_q <= '0;
    end else begin
      mem_q    <= mem_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
    end
  end

  assign result_o        = head.result;
  assign status_o        = head.status;
  assign extension_bit_o = head.ext;
  assign tag_o           = head.tag;
  assign fflags_o        = fflags_q;
  assign usage_o         = count_q;
  assign busy_o          = (count_q != '0);

endmodule

// File: tb/tb_fpnew_result_fifo.sv
// Bench for fpnew_result_fifo: vector table, directed corner
// sequences and a random run against a queue-based model.
module tb_fpnew_result_fifo;
  import fpnew_pkg::*;

  localparam int D = 4;

  logic        clk = 0;
  logic        rst_n;
  logic [31:0] result_i;
  status_t     status_i;
  logic        ext_i;
  logic [7:0]  tag_i;
  logic        in_valid, in_ready;
  logic        flush;
  logic [31:0] result_o;
  status_t     status_o;
  logic        ext_o;
  logic [7:0]  tag_o;
  logic        out_valid, out_ready;
  logic        clear_flags;
  status_t     fflags;
  logic [2:0]  usage;
  logic        busy;

  fpnew_result_fifo #(
    .Width(32), .Depth(D), .TagType(logic [7:0])
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .result_i(result_i), .status_i(status_i),
    .extension_bit_i(ext_i), .tag_i(tag_i),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .flush_i(flush),
    .result_o(result_o), .status_o(status_o),
    .extension_bit_o(ext_o), .tag_o(tag_o),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .clear_flags_i(clear_flags), .fflags_o(fflags),
    .usage_o(usage), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  s;
    logic        e;
    logic [7:0]  t;
  } ent_t;

  ent_t       mq[$];
  logic [4:0] mflags;
  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".usage"}, 64'(usage), 64'(mq.size()));
    chk({tag, ".busy"}, 64'(busy), 64'(mq.size() != 0));
    chk({tag, ".ovalid"}, 64'(out_valid), 64'(mq.size() != 0));
    chk({tag, ".iready"}, 64'(in_ready), 64'(mq.size() < D));
    chk({tag, ".fflags"}, 64'(fflags), 64'(mflags));
    if (mq.size() != 0) begin
      chk({tag, ".result"}, 64'(result_o), 64'(mq[0].r));
      chk({tag, ".status"}, 64'(status_o), 64'(mq[0].s));
      chk({tag, ".ext"}, 64'(ext_o), 64'(mq[0].e));
      chk({tag, ".tag"}, 64'(tag_o), 64'(mq[0].t));
    end
  endtask

  // one clock: drive, advance model at the edge, compare
  task automatic cyc(logic iv, logic ordy, logic fl, logic cl,
                     logic [7:0] t, logic [4:0] s,
                     logic [31:0] r, logic e, string name);
    bit   do_push, do_pop;
    ent_t x;
    in_valid = iv; out_ready = ordy; flush = fl;
    clear_flags = cl; tag_i = t; status_i = s;
    result_i = r; ext_i = e;
    do_push = iv && !fl && (mq.size() < D);
    do_pop  = ordy && !fl && (mq.size() > 0);
    @(posedge clk);
    if (cl) mflags = '0;
    if (fl) mq.delete();
    if (do_pop) begin
      x = mq.pop_front();
      mflags |= x.s;
    end
    if (do_push) mq.push_back('{r, s, e, t});
    #1;
    chk_model(name);
  endtask

  typedef struct {
    logic       iv, ordy;
    logic [7:0] t;
    logic [2:0] e_usage;
    logic       e_ov, e_ir;
    logic [7:0] e_tag;
  } vec_t;

  vec_t vt[8];

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 0; flush = 0;
    clear_flags = 0; tag_i = 0; status_i = '0;
    result_i = 0; ext_i = 0; mflags = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.usage", 64'(usage), 0);
    chk("rst.ovalid", 64'(out_valid), 0);
    chk("rst.busy", 64'(busy), 0);
    chk("rst.iready", 64'(in_ready), 1);
    chk("rst.fflags", 64'(fflags), 0);
    @(negedge clk);
    rst_n = 1;

    // fill to full, blocked push while full, drain in order
    vt[0] = '{1, 0, 8'd1, 3'd1, 1, 1, 8'd1};
    vt[1] = '{1, 0, 8'd2, 3'd2, 1, 1, 8'd1};
    vt[2] = '{1, 0, 8'd3, 3'd3, 1, 1, 8'd1};
    vt[3] = '{1, 0, 8'd4, 3'd4, 1, 0, 8'd1};
    vt[4] = '{1, 1, 8'd9, 3'd3, 1, 1, 8'd2};
    vt[5] = '{0, 1, 8'd0, 3'd2, 1, 1, 8'd3};
    vt[6] = '{0, 1, 8'd0, 3'd1, 1, 1, 8'd4};
    vt[7] = '{0, 1, 8'd0, 3'd0, 0, 1, 8'd0};
    for (int i = 0; i < 8; i++) begin
      cyc(vt[i].iv, vt[i].ordy, 0, 0, vt[i].t, 5'd0,
          32'(i) * 32'h1111, 0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.usage_k", i), 64'(usage),
          64'(vt[i].e_usage));
      chk($sformatf("vec%0d.ov_k", i), 64'(out_valid),
          64'(vt[i].e_ov));
      chk($sformatf("vec%0d.ir_k", i), 64'(in_ready),
          64'(vt[i].e_ir));
      if (vt[i].e_ov)
        chk($sformatf("vec%0d.tag_k", i), 64'(tag_o),
            64'(vt[i].e_tag));
    end

    // streaming through the wrap point
    for (int k = 0; k < 10; k++) begin
      cyc(1, 1, 0, 0, 8'(8'h20 + k), 5'd0, 32'(k), k[0],
          "stream");
      chk("stream.usage_k", 64'(usage), 1);
      chk("stream.tag_k", 64'(tag_o), 64'(8'h20 + k));
    end
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "stream.drain");

    // sticky flags, then clear together with a pop
    cyc(0, 0, 0, 1, 0, 0, 0, 0, "flg.clr0");
    cyc(1, 0, 0, 0, 8'h31, 5'b00001, 0, 0, "flg.p1");
    cyc(1, 0, 0, 0, 8'h32, 5'b10000, 0, 0, "flg.p2");
    cyc(1, 0, 0, 0, 8'h33, 5'b00100, 0, 0, "flg.p3");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "flg.pop1");
    chk("flg.after1", 64'(fflags), 64'(5'b00001));
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "flg.pop2");
    chk("flg.after2", 64'(fflags), 64'(5'b10001));
    cyc(0, 1, 0, 1, 0, 0, 0, 0, "flg.pop3clr");
    chk("flg.after3", 64'(fflags), 64'(5'b00100));

    // flush beats a concurrent push and pop
    for (int k = 0; k < 3; k++)
      cyc(1, 0, 0, 0, 8'(8'h40 + k), 5'b01000, 0, 0, "fl.fill");
    cyc(1, 1, 1, 0, 8'hEE, 5'b00010, 0, 0, "fl.flush");
    chk("fl.usage_k", 64'(usage), 0);
    chk("fl.ov_k", 64'(out_valid), 0);
    chk("fl.flags_k", 64'(fflags), 64'(5'b00100));
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "fl.idle");
    cyc(1, 1, 0, 0, 8'h50, 0, 0, 0, "fl.push");
    chk("fl.newtag", 64'(tag_o), 64'h50);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "fl.drain");

    // asynchronous reset with two entries held
    cyc(1, 0, 0, 0, 8'h61, 5'b00011, 0, 0, "rs.p1");
    cyc(1, 1, 0, 0, 8'h62, 0, 0, 0, "rs.p2");
    cyc(1, 0, 0, 0, 8'h63, 0, 0, 0, "rs.p3");
    in_valid = 0; out_ready = 0;
    #2 rst_n = 0;
    #1;
    chk("rs.usage", 64'(usage), 0);
    chk("rs.ovalid", 64'(out_valid), 0);
    chk("rs.busy", 64'(busy), 0);
    chk("rs.iready", 64'(in_ready), 1);
    chk("rs.fflags", 64'(fflags), 0);
    mq.delete();
    mflags = '0;
    @(negedge clk);
    rst_n = 1;
    cyc(1, 0, 0, 0, 8'h70, 5'b00001, 32'hCAFE, 1, "rs.push");
    chk("rs.ov_k", 64'(out_valid), 1);
    chk("rs.tag_k", 64'(tag_o), 64'h70);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "rs.drain");

    // random traffic
    for (int k = 0; k < 400; k++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 15) == 0,
          8'($urandom), 5'($urandom), $urandom,
          1'($urandom), "rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
